// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity-mode constants and data-width limits
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int NB_DATA_MIN = 5;
    localparam int NB_DATA_MAX = 9;

    // XOR over data and parity bit must equal 1 for odd parity, 0 for even.
    function automatic logic parity_error(input logic xor_all, input logic odd);
        return xor_all != (odd == PARITY_ODD);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// rtl/rx_sync.sv - two-flop synchroniser for an asynchronous input with a configurable reset value
module rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - oversampling UART receiver with runtime parity, error flags and break detect
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_rx,
    input  logic               i_parity_en,
    input  logic               i_parity_odd,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_done_tick,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_break
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(NB_DATA + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    logic rx_s;

    rx_state_t          state, state_n;
    logic [TW-1:0]      tick_cnt, tick_n;
    logic [BW-1:0]      bit_cnt, bit_n;
    logic [NB_DATA-1:0] shreg, sh_n;
    logic               par_en_q, pen_n, par_odd_q, podd_n, par_bit, pbit_n;
    logic               stop_idx, sidx_n, stop_lo, slo_n, stop_hi, shi_n;
    logic               wait_high, wait_n;
    logic [NB_DATA-1:0] data_n;
    logic               done_n, perr_n, ferr_n, brk_n;

    rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (i_clk),
        .reset (i_reset),
        .d     (i_rx),
        .q     (rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= IDLE;
            tick_cnt       <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            par_en_q       <= 1'b0;
            par_odd_q      <= 1'b0;
            par_bit        <= 1'b0;
            stop_idx       <= 1'b0;
            stop_lo        <= 1'b0;
            stop_hi        <= 1'b0;
            wait_high      <= 1'b0;
            o_rx_data      <= '0;
            o_rx_done_tick <= 1'b0;
            o_parity_err   <= 1'b0;
            o_frame_err    <= 1'b0;
            o_break        <= 1'b0;
        end else begin
            state          <= state_n;
            tick_cnt       <= tick_n;
            bit_cnt        <= bit_n;
            shreg          <= sh_n;
            par_en_q       <= pen_n;
            par_odd_q      <= podd_n;
            par_bit        <= pbit_n;
            stop_idx       <= sidx_n;
            stop_lo        <= slo_n;
            stop_hi        <= shi_n;
            wait_high      <= wait_n;
            o_rx_data      <= data_n;
            o_rx_done_tick <= done_n;
            o_parity_err   <= perr_n;
            o_frame_err    <= ferr_n;
            o_break        <= brk_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        pen_n   = par_en_q;
        podd_n  = par_odd_q;
        pbit_n  = par_bit;
        sidx_n  = stop_idx;
        slo_n   = stop_lo;
        shi_n   = stop_hi;
        wait_n  = wait_high;
        data_n  = o_rx_data;
        done_n  = 1'b0;
        perr_n  = o_parity_err;
        ferr_n  = o_frame_err;
        brk_n   = o_break;
        case (state)
            IDLE: begin
                // After a break the line must go high before a new start is trusted.
                if (rx_s) begin
                    wait_n = 1'b0;
                end else if (!wait_high) begin
                    state_n = START;
                    tick_n  = '0;
                    bit_n   = '0;
                    sidx_n  = 1'b0;
                    slo_n   = 1'b0;
                    shi_n   = 1'b0;
                    pbit_n  = 1'b0;
                    pen_n   = i_parity_en;
                    podd_n  = i_parity_odd;
                end
            end
            START: if (i_s_tick) begin
                if (tick_cnt == TICK_MID) begin
                    tick_n  = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    tick_n = tick_cnt + 1'b1;
                end
            end
            DATA: if (i_s_tick) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_n = '0;
                    sh_n   = {rx_s, shreg[NB_DATA-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        bit_n   = '0;
                        state_n = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    tick_n = tick_cnt + 1'b1;
                end
            end
            PARITY: if (i_s_tick) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_n  = '0;
                    pbit_n  = rx_s;
                    state_n = STOP;
                end else begin
                    tick_n = tick_cnt + 1'b1;
                end
            end
            STOP: if (i_s_tick) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_n = '0;
                    if (rx_s) shi_n = 1'b1;
                    else      slo_n = 1'b1;
                    if (stop_idx == STOP_LAST) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        data_n  = shreg;
                        ferr_n  = slo_n;
                        perr_n  = par_en_q && parity_error(^shreg ^ par_bit, par_odd_q);
                        brk_n   = (shreg == '0) && !(par_en_q && par_bit) && !shi_n;
                        wait_n  = brk_n;
                    end else begin
                        sidx_n = 1'b1;
                    end
                end else begin
                    tick_n = tick_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg against a frame-level reference model
module tb_uart_rx_cfg;

    localparam int BIT = 144;

    logic       clk = 1'b0;
    logic       reset, rst1;
    logic       s_tick = 1'b0;
    int         tdiv = 0;
    logic [2:0] rx;
    logic       parity_en, parity_odd;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [2:0] done, perr, ferr, brk;

    logic [11:0] got_q [3][$];
    logic [11:0] exp_q [3][$];
    logic [11:0] last_exp [3];
    int          n_checks = 0;
    int          n_err = 0;

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (tdiv == 8) begin
            tdiv   <= 0;
            s_tick <= 1'b1;
        end else begin
            tdiv   <= tdiv + 1;
            s_tick <= 1'b0;
        end
    end

    uart_rx_cfg #(.NB_DATA(8), .OVERSAMPLE(16), .STOP_BITS(1)) u0 (
        .i_clk(clk), .i_reset(reset), .i_s_tick(s_tick), .i_rx(rx[0]),
        .i_parity_en(parity_en), .i_parity_odd(parity_odd),
        .o_rx_data(d0), .o_rx_done_tick(done[0]), .o_parity_err(perr[0]),
        .o_frame_err(ferr[0]), .o_break(brk[0])
    );

    uart_rx_cfg #(.NB_DATA(8), .OVERSAMPLE(16), .STOP_BITS(2)) u1 (
        .i_clk(clk), .i_reset(reset | rst1), .i_s_tick(s_tick), .i_rx(rx[1]),
        .i_parity_en(parity_en), .i_parity_odd(parity_odd),
        .o_rx_data(d1), .o_rx_done_tick(done[1]), .o_parity_err(perr[1]),
        .o_frame_err(ferr[1]), .o_break(brk[1])
    );

    uart_rx_cfg #(.NB_DATA(7), .OVERSAMPLE(16), .STOP_BITS(1)) u2 (
        .i_clk(clk), .i_reset(reset), .i_s_tick(s_tick), .i_rx(rx[2]),
        .i_parity_en(parity_en), .i_parity_odd(parity_odd),
        .o_rx_data(d2), .o_rx_done_tick(done[2]), .o_parity_err(perr[2]),
        .o_frame_err(ferr[2]), .o_break(brk[2])
    );

    always @(negedge clk) begin
        if (done[0]) got_q[0].push_back({1'b0, d0, perr[0], ferr[0], brk[0]});
        if (done[1]) got_q[1].push_back({1'b0, d1, perr[1], ferr[1], brk[1]});
        if (done[2]) got_q[2].push_back({2'b0, d2, perr[2], ferr[2], brk[2]});
    end

    function automatic logic [11:0] cur(input int i);
        case (i)
            0:       return {1'b0, d0, perr[0], ferr[0], brk[0]};
            1:       return {1'b0, d1, perr[1], ferr[1], brk[1]};
            default: return {2'b0, d2, perr[2], ferr[2], brk[2]};
        endcase
    endfunction

    // Expected result of a frame, from the bit values the line carried.
    function automatic logic [11:0] model(input int nb, input logic [8:0] data, input logic pen,
                                          input logic odd, input logic pbit, input int nstop,
                                          input logic [1:0] stops);
        logic [8:0] dm;
        logic lo, hi, pe, br;
        dm = data & 9'((1 << nb) - 1);
        lo = 1'b0;
        hi = 1'b0;
        for (int i = 0; i < nstop; i++) begin
            if (stops[i]) hi = 1'b1;
            else          lo = 1'b1;
        end
        pe = pen && ((^dm ^ pbit) != odd);
        br = (dm == 9'd0) && !(pen && pbit) && !hi;
        return {dm, pe, lo, br};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input int which, input int nb, input logic [8:0] data, input logic pbit,
                        input int nstop, input logic [1:0] stops, input bit push);
        logic [15:0] bits;
        int n;
        logic pen, odd;
        pen  = parity_en;
        odd  = parity_odd;
        bits = '0;
        n    = 1;
        for (int i = 0; i < nb; i++) begin bits[n] = data[i]; n++; end
        if (pen) begin bits[n] = pbit; n++; end
        for (int i = 0; i < nstop; i++) begin bits[n] = stops[i]; n++; end
        if (push) begin
            last_exp[which] = model(nb, data, pen, odd, pbit, nstop, stops);
            exp_q[which].push_back(last_exp[which]);
        end
        for (int i = 0; i < n; i++) begin
            rx[which] = bits[i];
            repeat (BIT) @(negedge clk);
        end
        rx[which] = 1'b1;
    endtask

    task automatic gap(input int nbits);
        repeat (nbits * BIT) @(negedge clk);
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            check({tag, " done count"}, 32'(got_q[i].size()), 32'(exp_q[i].size()));
            while (got_q[i].size() > 0 && exp_q[i].size() > 0)
                check({tag, " frame"}, 32'(got_q[i].pop_front()), 32'(exp_q[i].pop_front()));
            got_q[i].delete();
            exp_q[i].delete();
        end
    endtask

    initial begin
        logic [8:0] data;
        logic       pbit;
        rx         = 3'b111;
        reset      = 1'b1;
        rst1       = 1'b0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        for (int i = 0; i < 3; i++) last_exp[i] = '0;
        repeat (5) @(negedge clk);
        check("reset out0", 32'(cur(0)), 32'd0);
        check("reset out2", 32'(cur(2)), 32'd0);
        reset = 1'b0;
        gap(1);

        send(0, 8, 9'h055, 1'b0, 1, 2'b11, 1);
        send(0, 8, 9'h0A3, 1'b0, 1, 2'b11, 1);
        gap(1);
        compare_all("b2b");

        parity_en = 1'b1; parity_odd = 1'b0;
        send(0, 8, 9'h0A3, 1'b0, 1, 2'b11, 1); gap(1);
        send(0, 8, 9'h0A3, 1'b1, 1, 2'b11, 1); gap(1);
        compare_all("even");

        parity_odd = 1'b1;
        send(0, 8, 9'h000, 1'b1, 1, 2'b11, 1); gap(1);
        send(1, 8, 9'h000, 1'b1, 2, 2'b01, 1); gap(1);
        compare_all("odd/stop2");
        rst1 = 1'b1; @(negedge clk); rst1 = 1'b0;
        last_exp[1] = '0;

        send(0, 8, 9'h0C5, 1'b1, 1, 2'b11, 1); gap(1);
        parity_en = 1'b0;
        rx[0] = 1'b0;
        repeat (36) @(negedge clk);
        rx[0] = 1'b1;
        gap(2);
        check("false start hold", 32'(cur(0)), 32'(last_exp[0]));
        compare_all("false start");
        send(0, 8, 9'h03C, 1'b0, 1, 2'b11, 1); gap(1);
        compare_all("after false");

        rx[0] = 1'b0;
        last_exp[0] = model(8, 9'h000, 1'b0, 1'b0, 1'b0, 1, 2'b00);
        exp_q[0].push_back(last_exp[0]);
        gap(12);
        compare_all("break low");
        rx[0] = 1'b1;
        gap(2);
        check("break hold", 32'(cur(0)), 32'(last_exp[0]));
        send(0, 8, 9'h05A, 1'b0, 1, 2'b11, 1); gap(1);
        compare_all("after break");

        for (int k = 0; k < 6; k++) begin
            data       = 9'($urandom_range(0, 255));
            pbit       = 1'($urandom);
            parity_en  = 1'($urandom);
            parity_odd = 1'($urandom);
            fork
                send(0, 8, data, pbit, 1, 2'b11, 1);
                begin
                    repeat (3 * BIT) @(negedge clk);
                    parity_en  = 1'($urandom);
                    parity_odd = 1'($urandom);
                end
            join
            gap(1);
        end
        compare_all("random");

        parity_en = 1'b0;
        fork
            send(0, 8, 9'h0FF, 1'b0, 1, 2'b11, 0);
            begin
                repeat (5 * BIT + BIT / 2) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        join
        gap(1);
        for (int i = 0; i < 3; i++) last_exp[i] = '0;
        check("midframe reset out0", 32'(cur(0)), 32'd0);
        compare_all("midframe reset");
        send(0, 8, 9'h081, 1'b0, 1, 2'b11, 1); gap(1);
        compare_all("after reset");

        send(2, 7, 9'h07F, 1'b0, 1, 2'b11, 1); gap(1);
        compare_all("nb7");
        check("nb7 data", 32'(d2), 32'h7F);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
